// File: rtl/register_file_mp.sv
// Multi-port integer register file with optional zero register, write-to-read bypass and pending scoreboard.
// Reads are combinational (zero latency); writes and scoreboard updates land on the rising edge; no backpressure.
module register_file_mp #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_READ*AW-1:0]    read_address,
    output logic [NUM_READ*XLEN-1:0]  read_data,
    output logic [NUM_READ-1:0]       read_busy,
    input  logic [NUM_WRITE-1:0]      write_enable,
    input  logic [NUM_WRITE*AW-1:0]   write_address,
    input  logic [NUM_WRITE*XLEN-1:0] write_data,
    input  logic                      reserve_enable,
    input  logic [AW-1:0]             reserve_address,
    input  logic                      flush,
    output logic [NUM_REGS-1:0]       pending
);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;

    logic [AW-1:0]        w_wa [NUM_WRITE];
    logic [XLEN-1:0]      w_wd [NUM_WRITE];
    logic [NUM_WRITE-1:0] w_wr_eff;
    logic [NUM_REGS-1:0]  w_wr_hit;
    logic [NUM_REGS-1:0]  w_rsv_hit;
    logic [AW-1:0]        w_ra [NUM_READ];
    logic [NUM_READ-1:0]  w_byp;

    // Addresses past the end of a non-power-of-two file and the hardwired zero register hold no state.
    function automatic logic f_usable(input logic [AW-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        w_wr_hit  = '0;
        w_rsv_hit = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            w_wa[w]     = write_address[w*AW +: AW];
            w_wd[w]     = write_data[w*XLEN +: XLEN];
            w_wr_eff[w] = write_enable[w] && f_usable(w_wa[w]);
            if (w_wr_eff[w]) w_wr_hit[w_wa[w]] = 1'b1;
        end
        if (reserve_enable && f_usable(reserve_address)) w_rsv_hit[reserve_address] = 1'b1;
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            w_ra[i]  = read_address[i*AW +: AW];
            w_byp[i] = 1'b0;
            read_data[i*XLEN +: XLEN] = f_usable(w_ra[i]) ? r_regs[w_ra[i]] : '0;
            if (BYPASS != 0) begin
                // Ascending scan so the highest-index matching port wins, as it does at the edge.
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (w_wr_eff[w] && (w_wa[w] == w_ra[i])) begin
                        read_data[i*XLEN +: XLEN] = w_wd[w];
                        w_byp[i] = 1'b1;
                    end
                end
            end
            read_busy[i] = f_usable(w_ra[i]) && r_pending[w_ra[i]] && !w_byp[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (w_wr_eff[w]) r_regs[w_wa[w]] <= w_wd[w];
            end
        end
    end

    // Reservation beats flush, flush beats write-completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_rsv_hit | (r_pending & ~(flush ? {NUM_REGS{1'b1}} : w_wr_hit));
        end
    end

    assign pending = r_pending;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default build (zero reg, bypass) and a 24x64 4R/3W build without either.
module tb_register_file_mp;

    localparam int K_RDA = 0, K_BSA = 1, K_PNA = 2, K_RDB = 3, K_BSB = 4, K_PNB = 5;

    typedef struct {
        int          kind;
        int          port;
        logic [63:0] exp;
        logic [95:0] name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [9:0]   a_raddr = '0;
    logic [63:0]  a_rdata;
    logic [1:0]   a_busy;
    logic [1:0]   a_we = '0;
    logic [9:0]   a_waddr = '0;
    logic [63:0]  a_wdata = '0;
    logic         a_rsv_en = 1'b0;
    logic [4:0]   a_rsv_addr = '0;
    logic         a_flush = 1'b0;
    logic [31:0]  a_pend;

    logic [19:0]  b_raddr = '0;
    logic [255:0] b_rdata;
    logic [3:0]   b_busy;
    logic [2:0]   b_we = '0;
    logic [14:0]  b_waddr = '0;
    logic [191:0] b_wdata = '0;
    logic         b_rsv_en = 1'b0;
    logic [4:0]   b_rsv_addr = '0;
    logic         b_flush = 1'b0;
    logic [23:0]  b_pend;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic done = 1'b0;

    logic [63:0] m_reg [24];
    logic [23:0] m_pend;

    register_file_mp dut_a (
        .clk(clk), .rst(rst),
        .read_address(a_raddr), .read_data(a_rdata), .read_busy(a_busy),
        .write_enable(a_we), .write_address(a_waddr), .write_data(a_wdata),
        .reserve_enable(a_rsv_en), .reserve_address(a_rsv_addr), .flush(a_flush),
        .pending(a_pend)
    );

    register_file_mp #(
        .XLEN(64), .NUM_REGS(24), .NUM_READ(4), .NUM_WRITE(3), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .read_address(b_raddr), .read_data(b_rdata), .read_busy(b_busy),
        .write_enable(b_we), .write_address(b_waddr), .write_data(b_wdata),
        .reserve_enable(b_rsv_en), .reserve_address(b_rsv_addr), .flush(b_flush),
        .pending(b_pend)
    );

    always #5 clk = ~clk;

    // Monitor: everything queued since the last rising edge is compared mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_RDA:   act = {32'b0, a_rdata[e.port*32 +: 32]};
                K_BSA:   act = {63'b0, a_busy[e.port]};
                K_PNA:   act = {32'b0, a_pend};
                K_RDB:   act = b_rdata[e.port*64 +: 64];
                K_BSB:   act = {63'b0, b_busy[e.port]};
                default: act = {40'b0, b_pend};
            endcase
            n_chk++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s port%0d: got %h expected %h at %0t", e.name, e.port, act, e.exp, $time);
            end
        end
    end

    initial begin
        #1_000_000;
        n_chk++;
        if (!done) begin
            n_err++;
            $display("FAIL timeout: stimulus did not finish by %0t", $time);
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $finish;
        end
    end

    task automatic ex(input int kind, input int port, input logic [63:0] v, input logic [95:0] nm);
        exp_t e;
        e.kind = kind; e.port = port; e.exp = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic clr();
        a_we = '0; a_rsv_en = 1'b0; a_flush = 1'b0;
        b_we = '0; b_rsv_en = 1'b0; b_flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        // Reset state
        a_raddr[0 +: 5] = 5'd0;
        ex(K_PNA, 0, 64'h0, "rst_pend_a");
        ex(K_RDA, 0, 64'h0, "rst_rd_a");
        ex(K_PNB, 0, 64'h0, "rst_pend_b");
        step(); rst = 1'b0;

        // Write r5 with bypass visible, reserve r9
        step();
        a_we[0] = 1'b1; a_waddr[0 +: 5] = 5'd5; a_wdata[0 +: 32] = 32'hDEADBEEF;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
        a_raddr[0 +: 5] = 5'd5;
        ex(K_RDA, 0, 64'hDEADBEEF, "byp_r5");
        step();
        ex(K_RDA, 0, 64'hDEADBEEF, "hold_r5");
        ex(K_PNA, 0, 64'h200, "pend_r9");
        // Async reset between edges
        step(); rst = 1'b1;
        #1;
        n_chk++;
        if (a_rdata[31:0] !== 32'h0 || a_pend !== 32'h0 || b_pend !== 24'h0) begin
            n_err++;
            $display("FAIL arst_now: rd=%h pend_a=%h pend_b=%h at %0t", a_rdata[31:0], a_pend, b_pend, $time);
        end
        ex(K_RDA, 0, 64'h0, "arst_r5");
        ex(K_PNA, 0, 64'h0, "arst_pend");
        step(); rst = 1'b0;
        ex(K_RDA, 0, 64'h0, "post_rst_r5");

        // Bypass vs no bypass
        step();
        a_we[1] = 1'b1; a_waddr[5 +: 5] = 5'd7; a_wdata[32 +: 32] = 32'h12345678;
        a_raddr[0 +: 5] = 5'd7;
        b_we[1] = 1'b1; b_waddr[5 +: 5] = 5'd7; b_wdata[64 +: 64] = 64'h12345678;
        b_raddr[0 +: 5] = 5'd7;
        ex(K_RDA, 0, 64'h12345678, "byp_r7");
        ex(K_RDB, 0, 64'h0, "nobyp_r7");
        step();
        ex(K_RDA, 0, 64'h12345678, "hold_r7_a");
        ex(K_RDB, 0, 64'h12345678, "hold_r7_b");

        // Write collision and independent writes
        step();
        a_we = 2'b11;
        a_waddr[0 +: 5] = 5'd3; a_wdata[0 +: 32]  = 32'h1111;
        a_waddr[5 +: 5] = 5'd3; a_wdata[32 +: 32] = 32'h2222;
        a_raddr[0 +: 5] = 5'd3;
        ex(K_RDA, 0, 64'h2222, "coll_byp");
        step();
        a_we = 2'b11;
        a_waddr[0 +: 5] = 5'd4; a_wdata[0 +: 32]  = 32'h44;
        a_waddr[5 +: 5] = 5'd9; a_wdata[32 +: 32] = 32'h99;
        a_raddr[0 +: 5] = 5'd3; a_raddr[5 +: 5] = 5'd4;
        ex(K_RDA, 0, 64'h2222, "coll_r3");
        ex(K_RDA, 1, 64'h44, "byp_r4");
        step();
        a_raddr[0 +: 5] = 5'd4; a_raddr[5 +: 5] = 5'd9;
        ex(K_RDA, 0, 64'h44, "indep_r4");
        ex(K_RDA, 1, 64'h99, "indep_r9");

        // Zero register
        step();
        a_we[0] = 1'b1; a_waddr[0 +: 5] = 5'd0; a_wdata[0 +: 32] = 32'hFFFFFFFF;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd0; a_raddr[0 +: 5] = 5'd0;
        b_we[0] = 1'b1; b_waddr[0 +: 5] = 5'd0; b_wdata[0 +: 64] = 64'hFFFFFFFF;
        b_raddr[0 +: 5] = 5'd0;
        ex(K_RDA, 0, 64'h0, "zero_byp");
        ex(K_BSA, 0, 64'h0, "zero_busy");
        ex(K_RDB, 0, 64'h0, "r0b_old");
        step();
        ex(K_RDA, 0, 64'h0, "zero_rd");
        ex(K_PNA, 0, 64'h0, "zero_pend");
        ex(K_RDB, 0, 64'hFFFFFFFF, "r0b_new");

        // Scoreboard
        step();
        a_rsv_en = 1'b1; a_rsv_addr = 5'd10; a_raddr[0 +: 5] = 5'd10;
        b_rsv_en = 1'b1; b_rsv_addr = 5'd5;
        ex(K_BSA, 0, 64'h0, "busy_pre");
        step();
        a_raddr[0 +: 5] = 5'd10;
        b_we[2] = 1'b1; b_waddr[10 +: 5] = 5'd5; b_wdata[128 +: 64] = 64'h55;
        b_raddr[15 +: 5] = 5'd5;
        ex(K_BSA, 0, 64'h1, "busy_r10");
        ex(K_PNA, 0, 64'h400, "pend_r10");
        ex(K_BSB, 3, 64'h1, "busy_nobyp");
        ex(K_RDB, 3, 64'h0, "r5b_old");
        ex(K_PNB, 0, 64'h20, "pend_b_r5");
        step();
        a_we[0] = 1'b1; a_waddr[0 +: 5] = 5'd10; a_wdata[0 +: 32] = 32'hAA;
        a_raddr[5 +: 5] = 5'd10;
        b_raddr[15 +: 5] = 5'd5;
        ex(K_RDA, 1, 64'hAA, "byp_r10");
        ex(K_BSA, 1, 64'h0, "busy_byp");
        ex(K_PNA, 0, 64'h400, "pend_hold");
        ex(K_PNB, 0, 64'h0, "pend_b_clr");
        ex(K_RDB, 3, 64'h55, "r5b_new");
        ex(K_BSB, 3, 64'h0, "busy_b_clr");
        step();
        a_rsv_en = 1'b1; a_rsv_addr = 5'd10;
        a_we[1] = 1'b1; a_waddr[5 +: 5] = 5'd10; a_wdata[32 +: 32] = 32'hBB;
        a_raddr[5 +: 5] = 5'd10;
        ex(K_PNA, 0, 64'h0, "pend_wclr");
        ex(K_RDA, 1, 64'hBB, "byp_r10b");
        ex(K_BSA, 1, 64'h0, "busy_r10b");
        // Out-of-range address on the 24-entry build
        b_we = 3'b101;
        b_waddr[0 +: 5]  = 5'd30; b_wdata[0 +: 64]   = 64'hDEAD;
        b_waddr[10 +: 5] = 5'd23; b_wdata[128 +: 64] = 64'h0123_4567_89AB_CDEF;
        b_rsv_en = 1'b1; b_rsv_addr = 5'd30;
        b_raddr[0 +: 5] = 5'd30; b_raddr[5 +: 5] = 5'd6;
        ex(K_RDB, 0, 64'h0, "oor_rd");
        ex(K_BSB, 0, 64'h0, "oor_busy");
        ex(K_RDB, 1, 64'h0, "alias_r6");
        step();
        a_rsv_en = 1'b1; a_rsv_addr = 5'd2;
        b_raddr[0 +: 5] = 5'd30; b_raddr[5 +: 5] = 5'd6; b_raddr[10 +: 5] = 5'd23;
        ex(K_PNA, 0, 64'h400, "rsv_beats_wr");
        ex(K_RDB, 0, 64'h0, "oor_rd2");
        ex(K_RDB, 1, 64'h0, "alias_r6b");
        ex(K_RDB, 2, 64'h0123_4567_89AB_CDEF, "r23_top");
        ex(K_PNB, 0, 64'h0, "oor_pend");

        // Flush
        step(); a_rsv_en = 1'b1; a_rsv_addr = 5'd6;
        step(); a_rsv_en = 1'b1; a_rsv_addr = 5'd8;
        step();
        a_flush = 1'b1; a_rsv_en = 1'b1; a_rsv_addr = 5'd11;
        ex(K_PNA, 0, 64'h544, "pre_flush");
        step();
        a_flush = 1'b1; a_rsv_en = 1'b1; a_rsv_addr = 5'd11;
        ex(K_PNA, 0, 64'h800, "flush_r11");
        step();
        a_raddr[0 +: 5] = 5'd11; a_raddr[5 +: 5] = 5'd2;
        ex(K_PNA, 0, 64'h800, "rsv_beats_fl");
        ex(K_BSA, 0, 64'h1, "busy_r11");
        ex(K_BSA, 1, 64'h0, "busy_r2");

        // Random traffic on the 24x64 build against a behavioural model
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        for (int r = 0; r < 24; r++) m_reg[r] = '0;
        m_pend = '0;
        for (int c = 0; c < 10000; c++) begin
            int wa [3];
            int ra;
            int rsv;
            step();
            for (int w = 0; w < 3; w++) begin
                wa[w] = $urandom_range(0, 31);
                b_we[w] = 1'($urandom_range(0, 1));
                b_waddr[w*5 +: 5] = 5'(wa[w]);
                b_wdata[w*64 +: 64] = {$urandom, $urandom};
            end
            b_rsv_en = ($urandom_range(0, 3) == 0);
            rsv = $urandom_range(0, 31);
            b_rsv_addr = 5'(rsv);
            b_flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 4; i++) begin
                ra = (i == 3) ? wa[0] : $urandom_range(0, 31);
                b_raddr[i*5 +: 5] = 5'(ra);
                ex(K_RDB, i, (ra < 24) ? m_reg[ra] : 64'h0, "rand_rd");
                ex(K_BSB, i, {63'b0, (ra < 24) ? m_pend[ra] : 1'b0}, "rand_busy");
            end
            ex(K_PNB, 0, {40'b0, m_pend}, "rand_pend");
            for (int r = 0; r < 24; r++) begin
                logic hit;
                hit = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    if (b_we[w] && wa[w] == r) begin
                        m_reg[r] = b_wdata[w*64 +: 64];
                        hit = 1'b1;
                    end
                end
                if (b_rsv_en && rsv == r) m_pend[r] = 1'b1;
                else if (b_flush || hit) m_pend[r] = 1'b0;
            end
        end

        step();
        step();
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
